// File: rtl/sub52_iter.sv
// sub52_iter: iterative unsigned subtractor D = X - Y with borrow-out, CHUNK bits per cycle
module sub52_iter #(
   parameter int WIDTH = 52,
   parameter int CHUNK = 13
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] D,
   output logic             BO,
   output logic             busy
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   logic [1:0]       state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             borrow_q, borrow_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             bo_q, bo_d;
   logic [BW-1:0]    base;
   logic [CHUNK-1:0] x_chunk, y_chunk;
   logic [CHUNK:0]   diff;
   // Current chunk slice and its difference; bit CHUNK of diff is the chunk borrow.
   assign base    = BW'(idx_q * CHUNK);
   assign x_chunk = x_q[base +: CHUNK];
   assign y_chunk = y_q[base +: CHUNK];
   assign diff    = {1'b0, x_chunk} - {1'b0, y_chunk} - (CHUNK+1)'(borrow_q);
   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign D         = d_q;
   assign BO        = bo_q;
   // Next-state: capture in IDLE, one chunk per BUSY cycle, hold result in DONE; flush aborts.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      borrow_d = borrow_q;
      x_d      = x_q;
      y_d      = y_q;
      d_d      = d_q;
      bo_d     = bo_q;
      if (state_q == S_IDLE) begin
         if (in_valid && !flush) begin
            x_d      = X;
            y_d      = Y;
            idx_d    = '0;
            borrow_d = 1'b0;
            d_d      = '0;
            state_d  = S_BUSY;
         end
      end else if (state_q == S_BUSY) begin
         if (flush) begin
            state_d = S_IDLE;
         end else begin
            d_d[base +: CHUNK] = diff[CHUNK-1:0];
            borrow_d           = diff[CHUNK];
            idx_d              = idx_q + 1'b1;
            if (idx_q == LAST) begin
               bo_d    = diff[CHUNK];
               state_d = S_DONE;
            end
         end
      end else begin
         state_d = (flush || out_ready) ? S_IDLE : S_DONE;
      end
   end
   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         borrow_q <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         d_q      <= '0;
         bo_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         borrow_q <= borrow_d;
         x_q      <= x_d;
         y_q      <= y_d;
         d_q      <= d_d;
         bo_q     <= bo_d;
      end
   end
endmodule

// File: tb/tb_sub52_iter.sv
// tb_sub52_iter: randomized self-checking bench for sub52_iter against an arithmetic model
module tb_sub52_iter;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [51:0] x_s = '0;
   logic [51:0] y_s = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [51:0] d_o;
   logic        bo_o;
   logic        busy;
   int          n_tests = 0;
   int          n_fail = 0;
   localparam logic [51:0] ALL1 = {52{1'b1}};
   localparam logic [51:0] PAT  = 52'hA_5A5A_5A5A_5A5A;

   sub52_iter dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .X(x_s), .Y(y_s), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .D(d_o), .BO(bo_o), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [52:0] ref_sub(input logic [51:0] x, input logic [51:0] y);
      ref_sub = {x < y, x - y};
   endfunction

   function automatic logic [51:0] rnd52();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      rnd52 = r[51:0];
   endfunction

   // Issue one op at a negedge, check latency and result; optionally release it.
   task automatic do_op(input logic [51:0] x, input logic [51:0] y, input bit rel);
      logic [52:0] e;
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready", in_ready, 1);
      in_valid = 1'b1;
      x_s = x;
      y_s = y;
      @(negedge clk);
      in_valid = 1'b0;
      x_s = rnd52();
      y_s = rnd52();
      chk("busy", busy, 1);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("latency", n, 4);
      e = ref_sub(x, y);
      chk("D", d_o, e[51:0]);
      chk("BO", bo_o, e[52]);
      if (rel) begin
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         chk("release_ready", in_ready, 1);
         chk("release_ov", out_valid, 0);
      end
   endtask

   initial begin
      logic [52:0] e;
      logic [51:0] a, b;
      #3;
      chk("rst_ov", out_valid, 0);
      chk("rst_rdy", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_D", d_o, 0);
      chk("rst_BO", bo_o, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      do_op(52'h1, 52'h0, 1);
      do_op(52'h0, 52'h1, 1);
      do_op(52'h2000, 52'h1, 1);
      do_op(PAT, PAT, 1);
      do_op(ALL1, 52'h0, 1);
      do_op(52'h0, ALL1, 1);
      do_op(ALL1, ALL1, 1);
      for (int i = 0; i < 40; i++) begin
         a = rnd52();
         b = ($urandom_range(0, 4) == 0) ? a : rnd52();
         do_op(a, b, 1);
      end
      // Backpressure: result held, new requests ignored.
      a = rnd52();
      b = rnd52();
      e = ref_sub(a, b);
      do_op(a, b, 0);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         x_s = rnd52();
         y_s = rnd52();
         @(negedge clk);
         chk("bp_D", d_o, e[51:0]);
         chk("bp_BO", bo_o, e[52]);
         chk("bp_rdy", in_ready, 0);
         chk("bp_ov", out_valid, 1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_release", in_ready, 1);
      @(negedge clk);
      chk("bp_nocap", busy, 0);
      // Request with flush in IDLE is dropped.
      in_valid = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      flush = 1'b0;
      chk("idle_flush_busy", busy, 0);
      chk("idle_flush_rdy", in_ready, 1);
      // Flush in the second BUSY cycle.
      in_valid = 1'b1;
      x_s = rnd52();
      y_s = rnd52();
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("fl_rdy", in_ready, 1);
      chk("fl_busy", busy, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("fl_ov", out_valid, 0);
      end
      // Flush in DONE beats out_ready.
      do_op(52'h12345, 52'h54321, 0);
      flush = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      out_ready = 1'b0;
      chk("fd_ov", out_valid, 0);
      chk("fd_rdy", in_ready, 1);
      do_op(52'h0_0000_0001_0000, 52'h0_0000_0000_0001, 1);
      // Asynchronous reset in BUSY.
      in_valid = 1'b1;
      x_s = ALL1;
      y_s = 52'h1;
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar_ov", out_valid, 0);
      chk("ar_rdy", in_ready, 1);
      chk("ar_busy", busy, 0);
      chk("ar_D", d_o, 0);
      chk("ar_BO", bo_o, 0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("ar_noresult", out_valid, 0);
      end
      do_op(PAT, 52'h1, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
